button_monitor_debounced: RTL and testbench
===========================================

Name: button_monitor_debounced

Overview:
Parametrised successor to the N-bit button edge monitor. Each of WIDTH push-button inputs is synchronised and debounced, then converted to clean one-cycle press/release pulses. The block also provides a long-press (hold) indication and optional auto-repeat press pulses while a key stays held. It sits between the raw board keys and the lock/keypad control FSMs, replacing the undebounced edge detector.

Parameters:
WIDTH, 4, number of independent key channels
ACTIVE_LOW, 1, 1 = key pressed when input is 0 (board buttons); 0 = pressed when 1
DEBOUNCE_CYCLES, 50000, consecutive clocks a new level must persist before it is accepted (>=1)
HOLD_CYCLES, 25000000, clocks after the accepted press before keyHold fires (>=1)
REPEAT_EN, 1, 1 = emit repeated keyPress pulses while held past HOLD_CYCLES
REPEAT_CYCLES, 5000000, period of auto-repeat keyPress pulses (>=1)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
key  input  WIDTH  raw asynchronous button levels
keyState  output  WIDTH  debounced level per channel, 1 = pressed (polarity normalised)
keyPress  output  WIDTH  one-cycle pulse on accepted press, and on each auto-repeat
keyRelease  output  WIDTH  one-cycle pulse on accepted release
keyHold  output  WIDTH  one-cycle pulse when a press has lasted HOLD_CYCLES

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low.
- Reset (reset=0, async): all outputs 0. Synchroniser flops load the not-pressed level (1 if ACTIVE_LOW), so releasing reset with keys idle yields no pulse. Counters are 0 and every channel FSM is IDLE.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Synchroniser: 2 flops per bit, then polarity normalisation to pressed=1.
- Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
  - Increments each cycle while the synced level differs from keyState.
  - Clears on any cycle where they match, so a glitch restarts the count.
  - When the count reaches DEBOUNCE_CYCLES, keyState toggles and the counter clears, both on the same edge.
- Latency: edge E1 first samples the new level. keyState changes, and keyPress/keyRelease pulse, after edge E(DEBOUNCE_CYCLES+2). That is 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges.
- Per-channel FSM:
  - IDLE: keyState=0. Accepted press -> PRESSED, with keyPress=1 on that edge and the hold counter cleared.
  - PRESSED: the hold counter increments each cycle. When it reaches HOLD_CYCLES-1, keyHold pulses; -> REPEAT if REPEAT_EN, else HELD. The repeat counter is cleared.
  - REPEAT: the repeat counter increments. At REPEAT_CYCLES-1, keyPress pulses and the counter clears.
  - HELD: no further pulses.
  - Any state: accepted release -> IDLE, keyRelease=1, all counters cleared. Release takes priority over a hold or repeat pulse due on the same edge.
- Pulses are registered and last exactly one cycle. The first repeat keyPress comes REPEAT_CYCLES after keyHold.
- Counter widths come from $clog2 of the parameters. Counters saturate or clear as described and never wrap.
- Bounce shorter than DEBOUNCE_CYCLES produces no output change.
- Reset asserted mid-debounce or mid-hold aborts immediately. No pulse is emitted on reset assertion or deassertion.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, PRESSED, HELD, REPEAT, 2 bits) and a clog2 helper constant function.
- One sub-module, button_channel: synchroniser, debounce, FSM and counters for 1 bit, with the same parameters minus WIDTH.
- The top level is a generate loop of WIDTH button_channel instances.

Test Plan:
Bench parameters for all scenarios: WIDTH=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_EN=1, REPEAT_CYCLES=8.
1. Reset release with key=4'b1111 held 20 cycles -> keyState=0000; keyPress, keyRelease and keyHold all stay 0000.
2. key[0] driven 0 at edge E1 and held -> keyPress=0001 for one cycle after E6 and keyState[0]=1 from E6. Driving key[0] back to 1 -> keyRelease=0001 one cycle, 6 edges later.
3. key[1] bounces 0,1,0,1 with 3-cycle low periods, then stays high -> no pulses and keyState[1] stays 0.
4. key[2] held low 50 cycles -> keyPress at E6, keyHold at 16 cycles after the press, repeat keyPress every 8 cycles thereafter.
5. key[3:0]=0000 on the same edge -> keyPress=1111 in a single cycle. Then reset=0 for 1 cycle while held -> outputs 0 immediately. After reset release, the keys are re-accepted with fresh keyPress=1111 at DEBOUNCE latency.
6. key[2] released exactly on its due repeat edge -> keyRelease=0100 and no keyPress in that cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/button_monitor_debounced_pkg.sv
// Shared types and helpers for the debounced button monitor: per-channel FSM
// state encoding and a counter-width helper that never returns zero.
package button_monitor_debounced_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2,
    ST_REPEAT  = 2'd3
  } chan_state_t;

  // Width needed to count 0..value-1, at least one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One key channel: two-flop synchroniser, polarity normalisation, debounce
// counter, and press/hold/repeat FSM producing registered one-cycle pulses.
module button_channel
  import button_monitor_debounced_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int DB_W   = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);
  localparam int REP_W  = clog2_min1(REPEAT_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_state;
  chan_state_t       r_fsm;
  chan_state_t       w_fsm_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [REP_W-1:0]  w_rep_cnt_nxt;
  logic              r_press;
  logic              r_release;
  logic              r_hold;
  logic              w_press_nxt;
  logic              w_release_nxt;
  logic              w_hold_nxt;
  logic              w_level;
  logic              w_differs;
  logic              w_accept;
  logic              w_acc_press;
  logic              w_acc_release;

  // Synchroniser resets to the idle raw level so reset release is silent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level       = r_sync2 ^ ACTIVE_LOW;
  assign w_differs     = (w_level != r_state);
  assign w_accept      = w_differs && (r_db_cnt == DB_LAST);
  assign w_acc_press   = w_accept && !r_state;
  assign w_acc_release = w_accept && r_state;

  // Final count edge toggles the level instead of reaching DEBOUNCE_CYCLES.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt <= '0;
      r_state  <= 1'b0;
    end else if (!w_differs) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_db_cnt <= '0;
      r_state  <= ~r_state;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm      <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_hold_cnt_nxt = r_hold_cnt;
    w_rep_cnt_nxt  = r_rep_cnt;
    if (w_acc_release) begin
      w_fsm_nxt      = ST_IDLE;
      w_hold_cnt_nxt = '0;
      w_rep_cnt_nxt  = '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_acc_press) begin
            w_fsm_nxt      = ST_PRESSED;
            w_hold_cnt_nxt = '0;
            w_rep_cnt_nxt  = '0;
          end
        end
        ST_PRESSED: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_fsm_nxt      = REPEAT_EN ? ST_REPEAT : ST_HELD;
            w_hold_cnt_nxt = '0;
            w_rep_cnt_nxt  = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (r_rep_cnt == REP_LAST) w_rep_cnt_nxt = '0;
          else                       w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
        ST_HELD: ;
        default: w_fsm_nxt = ST_IDLE;
      endcase
    end
  end

  // A release on the same edge suppresses any hold or repeat pulse.
  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = w_acc_release;
    w_hold_nxt    = 1'b0;
    if (!w_acc_release) begin
      case (r_fsm)
        ST_IDLE:    w_press_nxt = w_acc_press;
        ST_PRESSED: w_hold_nxt  = (r_hold_cnt == HOLD_LAST);
        ST_REPEAT:  w_press_nxt = (r_rep_cnt == REP_LAST);
        default:    ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;

endmodule

// File: rtl/button_monitor_debounced.sv
// Debounced multi-key monitor: WIDTH independent channels, each giving a clean
// level plus press, release, long-press and auto-repeat pulses.
module button_monitor_debounced
  import button_monitor_debounced_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] keyState,
  output logic [WIDTH-1:0] keyPress,
  output logic [WIDTH-1:0] keyRelease,
  output logic [WIDTH-1:0] keyHold
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .i_clk     (clock),
      .i_rst_n   (reset),
      .i_key     (key[gi]),
      .o_state   (keyState[gi]),
      .o_press   (keyPress[gi]),
      .o_release (keyRelease[gi]),
      .o_hold    (keyHold[gi])
    );
  end

endmodule

// File: tb/tb_button_monitor_debounced.sv
// Directed bench for button_monitor_debounced with short debounce/hold/repeat
// periods; expected pulses are hand-derived edge numbers after each key change.
module tb_button_monitor_debounced;

  logic       clock;
  logic       reset;
  logic [3:0] key;
  logic [3:0] keyState;
  logic [3:0] keyPress;
  logic [3:0] keyRelease;
  logic [3:0] keyHold;

  int n_cmp = 0;
  int n_err = 0;

  button_monitor_debounced #(
    .WIDTH           (4),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (16),
    .REPEAT_EN       (1'b1),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .keyState   (keyState),
    .keyPress   (keyPress),
    .keyRelease (keyRelease),
    .keyHold    (keyHold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic [3:0] st,
                         input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] hd);
    chk($sformatf("%s.state@%0d", tag, cyc), keyState, st);
    chk($sformatf("%s.press@%0d", tag, cyc), keyPress, pr);
    chk($sformatf("%s.release@%0d", tag, cyc), keyRelease, rl);
    chk($sformatf("%s.hold@%0d", tag, cyc), keyHold, hd);
  endtask

  initial begin
    logic [3:0] e_st;
    logic [3:0] e_pr;
    logic [3:0] e_rl;
    logic [3:0] e_hd;

    // Reset state with idle (high) keys
    reset = 1'b0;
    key   = 4'b1111;
    tick();
    tick();
    chk_all("rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;

    // 1: idle keys after reset release give no pulses
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all("idle", i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // 2: key[0] press accepted at E6, release accepted 6 edges after drive
    key = 4'b1110;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_st = (i >= 6) ? 4'b0001 : 4'b0000;
      e_pr = (i == 6) ? 4'b0001 : 4'b0000;
      chk_all("press0", i, e_st, e_pr, 4'b0000, 4'b0000);
    end
    key = 4'b1111;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_st = (i >= 6) ? 4'b0000 : 4'b0001;
      e_rl = (i == 6) ? 4'b0001 : 4'b0000;
      chk_all("rel0", i, e_st, 4'b0000, e_rl, 4'b0000);
    end

    // 3: key[1] bounce with 3-cycle lows never accepted
    for (int b = 0; b < 2; b++) begin
      key = 4'b1101;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk_all("bounce_lo", b * 6 + i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      key = 4'b1111;
      for (int i = 3; i < 6; i++) begin
        tick();
        chk_all("bounce_hi", b * 6 + i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
    end
    for (int i = 12; i < 22; i++) begin
      tick();
      chk_all("bounce_settle", i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // 4: key[2] held: press E6, hold E22, repeats E30/E38/E46/E54
    key = 4'b1011;
    for (int i = 1; i <= 56; i++) begin
      tick();
      e_st = (i >= 6) ? 4'b0100 : 4'b0000;
      e_pr = (i == 6 || i == 30 || i == 38 || i == 46 || i == 54) ? 4'b0100 : 4'b0000;
      e_hd = (i == 22) ? 4'b0100 : 4'b0000;
      chk_all("hold2", i, e_st, e_pr, 4'b0000, e_hd);
    end

    // 6: release accepted on E62, the edge the next repeat was due
    key = 4'b1111;
    for (int i = 57; i <= 64; i++) begin
      tick();
      e_st = (i >= 62) ? 4'b0000 : 4'b0100;
      e_rl = (i == 62) ? 4'b0100 : 4'b0000;
      chk_all("relrep2", i, e_st, 4'b0000, e_rl, 4'b0000);
    end
    for (int i = 65; i <= 90; i++) begin
      tick();
      chk_all("idle2", i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // 5: all keys pressed together, then reset mid-hold, then re-accept
    key = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_st = (i >= 6) ? 4'b1111 : 4'b0000;
      e_pr = (i == 6) ? 4'b1111 : 4'b0000;
      chk_all("all", i, e_st, e_pr, 4'b0000, 4'b0000);
    end
    reset = 1'b0;
    #1;
    chk_all("rst_async", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("rst_held", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      e_st = (i >= 6) ? 4'b1111 : 4'b0000;
      e_pr = (i == 6) ? 4'b1111 : 4'b0000;
      chk_all("reacc", i, e_st, e_pr, 4'b0000, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
